ddr2_controller_dmaster_bytes_to_packets: RTL and testbench
===========================================================

DDR2_CONTROLLER_DMASTER_BYTES_TO_PACKETS -- requirements
Module: ddr2_controller_dmaster_bytes_to_packets

Interface
REQ-001 The block SHALL have one parameter: CHANNEL_WIDTH, default 8, width of out_channel.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_ready  output  1  byte-stream sink ready.
- in_valid  input  1  byte-stream source valid.
- in_data  input  8  encoded byte.
- out_ready  input  1  packet sink ready (the downstream channel adapter).
- out_valid  output  1  packet beat valid.
- out_data  output  8  decoded payload byte.
- out_channel  output  CHANNEL_WIDTH  channel of the current beat.
- out_startofpacket  output  1  first beat of a packet.
- out_endofpacket  output  1  last beat of a packet.

Function
REQ-003 The block SHALL accept a byte on each cycle where in_valid and in_ready are both 1.
REQ-004 in_ready SHALL equal (!out_valid || out_ready), with no combinational path from in_valid.
REQ-005 Unescaped 0x7A (SOP) SHALL set sop_pending and produce no output beat.
REQ-006 Unescaped 0x7B (EOP) SHALL set eop_pending and produce no output beat.
REQ-007 Unescaped 0x7C (CHANNEL) SHALL enter channel-wait and produce no output beat.
REQ-008 Unescaped 0x7D (ESC) SHALL set esc_pending; the next accepted byte SHALL be XORed with 0x20 and treated as a non-marker.
REQ-009 In channel-wait, the next non-marker byte (escaped or not) SHALL load the channel register with its low CHANNEL_WIDTH bits and leave channel-wait, with no beat emitted.
REQ-010 An unescaped SOP, EOP or CHANNEL marker received in channel-wait SHALL abort channel-wait and be processed as a marker. An unescaped ESC in channel-wait SHALL NOT abort it.
REQ-011 Any other accepted byte SHALL be emitted as a beat on the next cycle (1-cycle latency), with:
- out_startofpacket = sop_pending
- out_endofpacket = eop_pending
- out_channel = the channel register
- sop_pending and eop_pending then cleared.
REQ-012 A repeated SOP or EOP marker before a data byte SHALL be idempotent.
REQ-013 The channel register SHALL persist across packets until reloaded.
REQ-014 A valid output beat SHALL hold out_data, out_channel, out_startofpacket and out_endofpacket stable until out_ready is 1.
REQ-015 A new beat SHALL load in the same cycle the held beat drains, so there are no bubbles at full throughput.
REQ-016 No accepted byte SHALL be dropped or duplicated under any backpressure pattern.

Reset
REQ-017 While reset is 1, at the next rising edge the block SHALL set:
- out_valid, out_startofpacket, out_endofpacket = 0
- out_data = 0x00
- out_channel = 0
- sop_pending, eop_pending, esc_pending, channel-wait = 0
REQ-018 Reset asserted mid-sequence (for example after ESC or CHANNEL) SHALL discard that partial state, and any held beat SHALL be lost.
REQ-019 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-020 The marker constants 0x7A, 0x7B, 0x7C, 0x7D and the escape mask 0x20 SHALL live in the shared package ddr2_controller_st_pkg.
REQ-021 The output register SHALL be the single sub-module ddr2_controller_st_pipeline_stage (a one-deep valid/ready register); the decode flags SHALL live in the top module.

Verification
REQ-022 Basic packet: bytes 7A 7C 00 41 7B 42 -> beats 0x41 (sop=1, eop=0, ch=0) then 0x42 (sop=0, eop=1, ch=0).
REQ-023 Escapes: bytes 7A 7D 5A 7B 7D 5D -> beats 0x7A (sop=1) then 0x7D (eop=1).
REQ-024 Channel, single-beat packet: bytes 7C 03 7A 7B 55 -> one beat 0x55 (sop=1, eop=1, ch=3); channel stays 3 for the next packet.
REQ-025 Backpressure: out_ready=0 for 3 cycles while a beat is held -> in_ready=0, outputs stable; the stream is then delivered complete and in order.
REQ-026 Marker in channel-wait: bytes 7C 7A 10 -> beat 0x10 (sop=1), channel unchanged.
REQ-027 Reset mid-escape: 7D, then reset, then 5A -> beat 0x5A (sop=0, eop=0, ch=0).

Source files
------------

// File: rtl/ddr2_controller_st_pkg.sv
// ddr2_controller_st_pkg: byte-stream marker constants and byte classification shared by the packet decoder.
package ddr2_controller_st_pkg;
  localparam logic [7:0] SOP_BYTE  = 8'h7A;
  localparam logic [7:0] EOP_BYTE  = 8'h7B;
  localparam logic [7:0] CHAN_BYTE = 8'h7C;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_MASK  = 8'h20;
  typedef enum logic [2:0] {CLS_DATA, CLS_SOP, CLS_EOP, CLS_CHAN, CLS_ESC} byte_cls_e;
  // A byte following ESC is always payload, whatever its value.
  function automatic byte_cls_e classify(input logic [7:0] b, input logic esc);
    if (esc) return CLS_DATA;
    if (b == SOP_BYTE) return CLS_SOP;
    if (b == EOP_BYTE) return CLS_EOP;
    if (b == CHAN_BYTE) return CLS_CHAN;
    if (b == ESC_BYTE) return CLS_ESC;
    return CLS_DATA;
  endfunction
endpackage

// File: rtl/ddr2_controller_st_pipeline_stage.sv
// ddr2_controller_st_pipeline_stage: one-deep valid/ready register that refills in the cycle it drains.
module ddr2_controller_st_pipeline_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
endmodule

// File: rtl/ddr2_controller_dmaster_bytes_to_packets.sv
// ddr2_controller_dmaster_bytes_to_packets: decodes an escaped byte stream with SOP/EOP/channel markers
// into packet beats carrying start/end flags and the current channel.
module ddr2_controller_dmaster_bytes_to_packets
  import ddr2_controller_st_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
);
  localparam int BW = CHANNEL_WIDTH + 10;
  logic                     r_sop, r_eop, r_esc, r_chw;
  logic [CHANNEL_WIDTH-1:0] r_channel;
  byte_cls_e                w_cls;
  logic [7:0]               w_byte;
  logic                     w_acc, w_emit;
  logic [BW-1:0]            w_beat;
  assign w_cls  = classify(in_data, r_esc);
  assign w_byte = r_esc ? in_data ^ ESC_MASK : in_data;
  assign w_acc  = in_valid && in_ready;
  assign w_emit = w_acc && w_cls == CLS_DATA && !r_chw;
  ddr2_controller_st_pipeline_stage #(.W(BW)) u_stage (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_emit),
    .o_ready (in_ready),
    .i_data  ({w_byte, r_sop, r_eop, r_channel}),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_beat)
  );
  assign {out_data, out_startofpacket, out_endofpacket, out_channel} = w_beat;
  // Channel-wait survives an ESC prefix but any other marker aborts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_esc     <= 1'b0;
      r_chw     <= 1'b0;
      r_channel <= '0;
    end else if (w_acc) begin
      r_esc <= w_cls == CLS_ESC;
      r_sop <= w_cls == CLS_SOP || (r_sop && !w_emit);
      r_eop <= w_cls == CLS_EOP || (r_eop && !w_emit);
      r_chw <= w_cls == CLS_CHAN || (r_chw && w_cls == CLS_ESC);
      if (r_chw && w_cls == CLS_DATA) r_channel <= CHANNEL_WIDTH'(w_byte);
    end
  end
endmodule

// File: tb/tb_ddr2_controller_dmaster_bytes_to_packets.sv
// tb_ddr2_controller_dmaster_bytes_to_packets: vector table, corner sequences and random stream against a reference decoder.
module tb_ddr2_controller_dmaster_bytes_to_packets;
  logic       clk = 0;
  logic       reset = 1;
  logic       in_ready, in_valid = 0;
  logic [7:0] in_data = 0;
  logic       out_ready = 1, out_valid;
  logic [7:0] out_data, out_channel;
  logic       out_startofpacket, out_endofpacket;
  int         checks = 0, passes = 0;
  int         bp_mode = 0;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  logic        hold = 0;
  logic [17:0] held;
  logic [17:0] cur;
  bit m_sop, m_eop, m_esc, m_chw;
  logic [7:0] m_ch;

  typedef struct {
    int          nb;
    logic [7:0]  b[8];
    int          n;
    logic [17:0] e[3];
  } vec_t;
  vec_t v[8];

  ddr2_controller_dmaster_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket)
  );

  always #5 clk = ~clk;
  assign cur = {out_data, out_startofpacket, out_endofpacket, out_channel};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!reset && hold) chk("hold_stable", {13'd0, out_valid, cur}, {13'd0, 1'b1, held});
    hold = !reset && out_valid && !out_ready;
    held = cur;
    if (!reset && out_valid && out_ready) got.push_back(cur);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : ($urandom_range(0, 99) < 60);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    in_valid = 1;
    in_data = b;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 300 && got.size() < n; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    chk("beat_count", got.size(), n);
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    m_sop = 0; m_eop = 0; m_esc = 0; m_chw = 0; m_ch = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] d;
    if (m_esc) begin
      m_esc = 0;
      d = b ^ 8'h20;
    end else begin
      d = b;
      if (b == 8'h7D) begin m_esc = 1; return; end
      if (b == 8'h7A) begin m_sop = 1; m_chw = 0; return; end
      if (b == 8'h7B) begin m_eop = 1; m_chw = 0; return; end
      if (b == 8'h7C) begin m_chw = 1; return; end
    end
    if (m_chw) begin
      m_ch = d;
      m_chw = 0;
    end else begin
      exp_q.push_back({d, m_sop, m_eop, m_ch});
      m_sop = 0;
      m_eop = 0;
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] b;
    v[0] = '{6, '{8'h7A, 8'h7C, 8'h00, 8'h41, 8'h7B, 8'h42, 0, 0}, 2, '{{8'h41, 2'b10, 8'h00}, {8'h42, 2'b01, 8'h00}, 0}};
    v[1] = '{6, '{8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D, 0, 0}, 2, '{{8'h7A, 2'b10, 8'h00}, {8'h7D, 2'b01, 8'h00}, 0}};
    v[2] = '{5, '{8'h7C, 8'h03, 8'h7A, 8'h7B, 8'h55, 0, 0, 0}, 1, '{{8'h55, 2'b11, 8'h03}, 0, 0}};
    v[3] = '{3, '{8'h7A, 8'h7B, 8'h66, 0, 0, 0, 0, 0}, 1, '{{8'h66, 2'b11, 8'h03}, 0, 0}};
    v[4] = '{3, '{8'h7C, 8'h7A, 8'h10, 0, 0, 0, 0, 0}, 1, '{{8'h10, 2'b10, 8'h03}, 0, 0}};
    v[5] = '{5, '{8'h7A, 8'h7A, 8'h7B, 8'h7B, 8'h01, 0, 0, 0}, 1, '{{8'h01, 2'b11, 8'h03}, 0, 0}};
    v[6] = '{4, '{8'h7C, 8'h7D, 8'h5C, 8'h02, 0, 0, 0, 0}, 1, '{{8'h02, 2'b00, 8'h7C}, 0, 0}};
    v[7] = '{6, '{8'h7D, 8'h7C, 8'h7D, 8'h7B, 8'h7D, 8'h7A, 0, 0}, 3,
             '{{8'h5C, 2'b00, 8'h7C}, {8'h5B, 2'b00, 8'h7C}, {8'h5A, 2'b00, 8'h7C}}};

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sop", out_startofpacket, 0);
    chk("rst_eop", out_endofpacket, 0);
    chk("rst_data", out_data, 0);
    chk("rst_channel", out_channel, 0);
    chk("rst_in_ready", in_ready, 1);

    bp_mode = 2;
    foreach (v[i]) begin
      got.delete();
      for (int j = 0; j < v[i].nb; j++) send_byte(v[i].b[j], ok);
      drain(v[i].n);
      for (int j = 0; j < v[i].n; j++) chk($sformatf("vec%0d_beat%0d", i, j), got.size() > j ? got[j] : 18'h3ffff, v[i].e[j]);
    end

    bp_mode = 1;
    tick();
    got.delete();
    send_byte(8'h11, ok);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_held_beat", {out_valid, cur}, {1'b1, 8'h11, 2'b00, 8'h7C});
      tick();
    end
    bp_mode = 0;
    send_byte(8'h22, ok);
    send_byte(8'h33, ok);
    drain(3);
    for (int j = 0; j < 3; j++) chk("bp_order", got.size() > j ? got[j][17:10] : 8'hff, 8'h11 * (j + 1));

    got.delete();
    send_byte(8'h7D, ok);
    do_reset();
    send_byte(8'h5A, ok);
    drain(1);
    chk("rst_mid_esc", got.size() > 0 ? got[0] : 18'h3ffff, {8'h5A, 2'b00, 8'h00});

    bp_mode = 1;
    tick();
    got.delete();
    send_byte(8'h44, ok);
    @(negedge clk);
    chk("held_before_rst", out_valid, 1);
    do_reset();
    bp_mode = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("held_lost_valid", out_valid, 0);
    chk("held_lost_count", got.size(), 0);

    do_reset();
    got.delete();
    exp_q.delete();
    bp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      b = r < 4 ? 8'h7A + 8'(r) : 8'($urandom_range(0, 255));
      send_byte(b, ok);
      if (ok) model_byte(b);
      if ($urandom_range(0, 4) == 0) tick();
    end
    drain(exp_q.size());
    foreach (exp_q[i]) chk($sformatf("rand_beat%0d", i), got.size() > i ? got[i] : 18'h3ffff, exp_q[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
